// File: rtl/carfield_regbus_decoder.sv
// Carfield RegBus decoder: forwards one outstanding request to one of NumSlv address windows.
// Optional downstream watchdog is compiled in with CARFIELD_REGBUS_TIMEOUT_EN.
//
// state | meaning
// IDLE  | waiting for an upstream request; decode and register payload
// FWD   | downstream valid held on the selected target until it is ready
// RESP  | one-cycle upstream completion with captured rdata/error
module carfield_regbus_decoder #(
  parameter int unsigned AddrWidth = 48,
  parameter int unsigned DataWidth = 32,
  parameter int unsigned NumSlv    = 5,
  // padframe, L2 ECC, PCRS, PLL, DMA SpW (index 0 is the rightmost element)
  parameter logic [NumSlv-1:0][AddrWidth-1:0] SlvBase = {48'h0000_2100_4000,
                                                         48'h0000_2100_3000,
                                                         48'h0000_2100_2000,
                                                         48'h0000_2100_1000,
                                                         48'h0000_2100_0000},
  parameter logic [NumSlv-1:0][AddrWidth-1:0] SlvSize = {5{48'h0000_0000_1000}},
  parameter logic [NumSlv-1:0] SlvEnable     = '1,
  parameter int unsigned       TimeoutCycles = 256
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          slv_req_valid_i,
  input  logic                          slv_req_write_i,
  input  logic [AddrWidth-1:0]          slv_req_addr_i,
  input  logic [DataWidth-1:0]          slv_req_wdata_i,
  input  logic [DataWidth/8-1:0]        slv_req_wstrb_i,
  output logic                          slv_rsp_ready_o,
  output logic [DataWidth-1:0]          slv_rsp_rdata_o,
  output logic                          slv_rsp_error_o,
  output logic [NumSlv-1:0]             mst_req_valid_o,
  output logic                          mst_req_write_o,
  output logic [AddrWidth-1:0]          mst_req_addr_o,
  output logic [DataWidth-1:0]          mst_req_wdata_o,
  output logic [DataWidth/8-1:0]        mst_req_wstrb_o,
  input  logic [NumSlv-1:0]             mst_rsp_ready_i,
  input  logic [NumSlv*DataWidth-1:0]   mst_rsp_rdata_i,
  input  logic [NumSlv-1:0]             mst_rsp_error_i
);

  localparam int unsigned SelW = (NumSlv > 1) ? $clog2(NumSlv) : 1;
  // PCRS (index 2) cannot be disabled by configuration
  localparam logic [NumSlv-1:0] PcrsMask = (NumSlv > 2) ? NumSlv'(3'b100) : '0;
  localparam logic [NumSlv-1:0] SlvEnEff = SlvEnable | PcrsMask;

  if (TimeoutCycles == 0) begin : g_bad_timeout
    $error("TimeoutCycles must be at least 1");
  end
  if (DataWidth % 8 != 0) begin : g_bad_width
    $error("DataWidth must be a multiple of 8");
  end

  typedef enum logic [1:0] {IDLE, FWD, RESP} state_e;

  state_e                 state_q, state_d;
  logic [SelW-1:0]        sel_q;
  logic                   write_q;
  logic [AddrWidth-1:0]   addr_q;
  logic [DataWidth-1:0]   wdata_q;
  logic [DataWidth/8-1:0] wstrb_q;
  logic [DataWidth-1:0]   rdata_q;
  logic                   error_q;

  logic                   hit;
  logic [SelW-1:0]        hit_idx;
  logic [AddrWidth-1:0]   hit_off;
  logic                   sel_ready;
  logic                   timeout;
  logic [NumSlv-1:0][DataWidth-1:0] rdata_arr;

  assign rdata_arr = mst_rsp_rdata_i;
  assign sel_ready = mst_rsp_ready_i[sel_q];

  // Descending scan so the lowest matching index is the one left standing.
  // The extra top bit keeps Base+Size from wrapping at the end of the space.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    hit_off = slv_req_addr_i;
    for (int i = NumSlv - 1; i >= 0; i--) begin
      if (SlvEnEff[i] &&
          ({1'b0, slv_req_addr_i} >= {1'b0, SlvBase[i]}) &&
          ({1'b0, slv_req_addr_i} < ({1'b0, SlvBase[i]} + {1'b0, SlvSize[i]}))) begin
        hit     = 1'b1;
        hit_idx = SelW'(i);
        hit_off = slv_req_addr_i - SlvBase[i];
      end
    end
  end

`ifdef CARFIELD_REGBUS_TIMEOUT_EN
  localparam int unsigned CntW = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;
  logic [CntW-1:0] cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)              cnt_q <= '0;
    else if (state_q != FWD)  cnt_q <= '0;
    else                      cnt_q <= cnt_q + CntW'(1);
  end

  assign timeout = (state_q == FWD) && (cnt_q == CntW'(TimeoutCycles - 1));
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (slv_req_valid_i) state_d = hit ? FWD : RESP;
      FWD:     if (sel_ready || timeout) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      sel_q   <= '0;
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      rdata_q <= '0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: if (slv_req_valid_i) begin
          write_q <= slv_req_write_i;
          addr_q  <= hit ? hit_off : slv_req_addr_i;
          wdata_q <= slv_req_wdata_i;
          wstrb_q <= slv_req_wstrb_i;
          sel_q   <= hit_idx;
          error_q <= ~hit;
          rdata_q <= (hit || slv_req_write_i) ? '0 : DataWidth'(32'hBADC_AB1E);
        end
        // a ready on the timeout cycle still completes normally
        FWD: if (sel_ready) begin
          rdata_q <= write_q ? '0 : rdata_arr[sel_q];
          error_q <= mst_rsp_error_i[sel_q];
        end else if (timeout) begin
          rdata_q <= write_q ? '0 : DataWidth'(32'hDEAD_BEEF);
          error_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign mst_req_valid_o = (state_q == FWD) ? (NumSlv'(1) << sel_q) : '0;
  assign mst_req_write_o = write_q;
  assign mst_req_addr_o  = addr_q;
  assign mst_req_wdata_o = wdata_q;
  assign mst_req_wstrb_o = wstrb_q;

  assign slv_rsp_ready_o = (state_q == RESP);
  assign slv_rsp_rdata_o = (state_q == RESP) ? rdata_q : '0;
  assign slv_rsp_error_o = (state_q == RESP) && error_q;

endmodule
